// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with a pixel request stage and a REQ_LEAD-deep sync/blank/data pipeline
module vga_timing_gen #(
  parameter int DATA_W   = 24,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACT    = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACT    = 480,
  parameter int V_FP     = 10,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              En,
  input  logic [DATA_W-1:0] DATA,
  output logic              Data_Req,
  output logic [11:0]       Pix_X,
  output logic [10:0]       Pix_Y,
  output logic              VGA_HS,
  output logic              VGA_VS,
  output logic              VGA_BLK,
  output logic [DATA_W-1:0] VGA_RGB,
  output logic              Frame_Start
);
  localparam int H_TOTAL = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACT + V_FP;
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_A0   = 12'(H_SYNC + H_BP);
  localparam logic [11:0] H_A1   = 12'(H_SYNC + H_BP + H_ACT - 1);
  localparam logic [11:0] H_S    = 12'(H_SYNC);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_A0   = 11'(V_SYNC + V_BP);
  localparam logic [10:0] V_A1   = 11'(V_SYNC + V_BP + V_ACT - 1);
  localparam logic [10:0] V_S    = 11'(V_SYNC);
  if (REQ_LEAD < 1 || REQ_LEAD > 4 || H_TOTAL > 4096 || V_TOTAL > 2048) begin : g_bad_params
    $error("vga_timing_gen: illegal parameter set");
  end
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d, pix_x_q, pix_x_d;
  logic [10:0] vcnt_q, vcnt_d, pix_y_q, pix_y_d;
  // bit 0 is the Data_Req stage; bit k is that stage delayed by k clocks
  logic [REQ_LEAD:0] req_q, req_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;
  logic run, h_last, v_last, act;
  always_comb begin
    run     = (state_q == RUN) || En;
    h_last  = hcnt_q == H_LAST;
    v_last  = vcnt_q == V_LAST;
    act     = run && hcnt_q >= H_A0 && hcnt_q <= H_A1 && vcnt_q >= V_A0 && vcnt_q <= V_A1;
    state_d = (run && !(h_last && v_last && !En)) ? RUN : IDLE;
    hcnt_d  = (!run || h_last) ? 12'd0 : hcnt_q + 12'd1;
    vcnt_d  = !run ? 11'd0 : h_last ? (v_last ? 11'd0 : vcnt_q + 11'd1) : vcnt_q;
    req_d   = {req_q[REQ_LEAD-1:0], act};
    hs_d    = {hs_q[REQ_LEAD-1:0], run && hcnt_q < H_S};
    vs_d    = {vs_q[REQ_LEAD-1:0], run && vcnt_q < V_S};
    fs_d    = {fs_q[REQ_LEAD-1:0], run && hcnt_q == 12'd0 && vcnt_q == 11'd0};
    pix_x_d = act ? hcnt_q - H_A0 : 12'd0;
    pix_y_d = act ? vcnt_q - V_A0 : 11'd0;
    rgb_d   = req_q[REQ_LEAD-1] ? DATA : '0;
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      req_q   <= '0;
      hs_q    <= '0;
      vs_q    <= '0;
      fs_q    <= '0;
      pix_x_q <= '0;
      pix_y_q <= '0;
      rgb_q   <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      req_q   <= req_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
      pix_x_q <= pix_x_d;
      pix_y_q <= pix_y_d;
      rgb_q   <= rgb_d;
    end
  end
  assign Data_Req    = req_q[0];
  assign Pix_X       = pix_x_q;
  assign Pix_Y       = pix_y_q;
  assign VGA_BLK     = req_q[REQ_LEAD];
  assign VGA_HS      = hs_q[REQ_LEAD] ? HS_POL : !HS_POL;
  assign VGA_VS      = vs_q[REQ_LEAD] ? VS_POL : !VS_POL;
  assign Frame_Start = fs_q[REQ_LEAD];
  assign VGA_RGB     = rgb_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: two small-raster instances (lead 1 active-low syncs, lead 3 active-high syncs) against a raster-position model
module tb_vga_timing_gen;
  logic Clk = 1'b0, Reset_n, En;
  logic [23:0] data1, data3, rgb1, rgb3;
  logic r1, hs1, vs1, blk1, fs1, r3, hs3, vs3, blk3, fs3;
  logic [11:0] px1, px3;
  logic [10:0] py1, py3;
  always #5 Clk = ~Clk;
  vga_timing_gen #(.DATA_W(24), .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(1)) u1 (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .DATA(data1), .Data_Req(r1), .Pix_X(px1), .Pix_Y(py1),
    .VGA_HS(hs1), .VGA_VS(vs1), .VGA_BLK(blk1), .VGA_RGB(rgb1), .Frame_Start(fs1));
  vga_timing_gen #(.DATA_W(24), .H_SYNC(2), .H_BP(2), .H_ACT(4), .H_FP(2), .V_SYNC(1), .V_BP(1), .V_ACT(3), .V_FP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(3)) u3 (
    .Clk(Clk), .Reset_n(Reset_n), .En(En), .DATA(data3), .Data_Req(r3), .Pix_X(px3), .Pix_Y(py3),
    .VGA_HS(hs3), .VGA_VS(vs3), .VGA_BLK(blk3), .VGA_RGB(rgb3), .Frame_Start(fs3));
  typedef struct {bit run; int h; int v;} snap_t;
  snap_t hist[$];
  bit mrun;
  int mh, mv, n_cmp, n_bad, cyc, cyc0, blk_cnt;
  int fs_times[$];
  function automatic bit act(snap_t s);
    return s.run && s.h >= 4 && s.h < 8 && s.v >= 2 && s.v < 5;
  endfunction
  function automatic logic [11:0] xpos(snap_t s);
    return act(s) ? 12'(s.h - 4) : 12'd0;
  endfunction
  function automatic logic [10:0] ypos(snap_t s);
    return act(s) ? 11'(s.v - 2) : 11'd0;
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock: model the raster position sampled at the next edge, then check both instances
  task automatic tick();
    snap_t s, d1, d3;
    bit last;
    if (!Reset_n) begin
      mrun = 0; mh = 0; mv = 0;
      foreach (hist[i]) hist[i].run = 0;
    end
    s.run = Reset_n && (mrun || En);
    s.h = mh;
    s.v = mv;
    hist.push_front(s);
    void'(hist.pop_back());
    last = mh == 9 && mv == 5;
    if (s.run) begin
      mrun = !(last && !En);
      mh = (mh + 1) % 10;
      if (mh == 0) mv = (mv + 1) % 6;
    end
    data1 = 24'($urandom);
    data3 = act(hist[3]) ? {1'b0, ypos(hist[3]), xpos(hist[3])} : 24'($urandom);
    @(posedge Clk);
    @(negedge Clk);
    cyc++;
    d1 = hist[1];
    d3 = hist[3];
    chk("req1", r1, act(hist[0]));
    chk("px1", px1, xpos(hist[0]));
    chk("py1", py1, ypos(hist[0]));
    chk("blk1", blk1, act(d1));
    chk("hs1", hs1, (d1.run && d1.h < 2) ? 0 : 1);
    chk("vs1", vs1, (d1.run && d1.v < 1) ? 0 : 1);
    chk("fs1", fs1, d1.run && d1.h == 0 && d1.v == 0);
    chk("rgb1", rgb1, act(d1) ? data1 : 24'd0);
    chk("req3", r3, act(hist[0]));
    chk("px3", px3, xpos(hist[0]));
    chk("py3", py3, ypos(hist[0]));
    chk("blk3", blk3, act(d3));
    chk("hs3", hs3, (d3.run && d3.h < 2) ? 1 : 0);
    chk("vs3", vs3, (d3.run && d3.v < 1) ? 1 : 0);
    chk("fs3", fs3, d3.run && d3.h == 0 && d3.v == 0);
    chk("rgb3", rgb3, act(d3) ? {1'b0, ypos(d3), xpos(d3)} : 24'd0);
    if (fs1) fs_times.push_back(cyc);
    if (blk1) blk_cnt++;
  endtask
  initial begin
    snap_t idle;
    idle.run = 0; idle.h = 0; idle.v = 0;
    for (int i = 0; i < 8; i++) hist.push_back(idle);
    Reset_n = 1'b0;
    En = 1'b0;
    data1 = '0;
    data3 = '0;
    repeat (3) tick();
    Reset_n = 1'b1;
    repeat (5) tick();
    En = 1'b1;
    fs_times.delete();
    blk_cnt = 0;
    cyc0 = cyc;
    repeat (120) tick();
    chk("fs_count", fs_times.size(), 2);
    chk("fs_first", fs_times.size() > 0 ? fs_times[0] - cyc0 : -1, 2);
    chk("frame_period", fs_times.size() > 1 ? fs_times[1] - fs_times[0] : -1, 60);
    chk("blk_two_frames", blk_cnt, 24);
    for (int i = 0; i < 60 && (mh + 10 * mv) != 20; i++) tick();
    En = 1'b0;
    fs_times.delete();
    blk_cnt = 0;
    repeat (80) tick();
    chk("blk_after_drop", blk_cnt, 12);
    chk("fs_after_drop", fs_times.size(), 0);
    chk("idle_levels", {blk1, r1, fs1, hs1, vs1, hs3, vs3}, 7'b0001100);
    repeat (5) tick();
    En = 1'b1;
    fs_times.delete();
    cyc0 = cyc;
    repeat (4) tick();
    chk("fs_after_en", fs_times.size() > 0 ? fs_times[0] - cyc0 : -1, 2);
    for (int i = 0; i < 400; i++) begin
      En = $urandom_range(0, 7) != 0;
      tick();
    end
    En = 1'b1;
    for (int i = 0; i < 100 && !act(hist[1]); i++) tick();
    chk("blk_before_reset", blk1, 1);
    Reset_n = 1'b0;
    #1;
    chk("async_blk1", blk1, 0);
    chk("async_req1", r1, 0);
    chk("async_rgb1", rgb1, 0);
    chk("async_req3", r3, 0);
    chk("async_rgb3", rgb3, 0);
    chk("async_hs1", hs1, 1);
    chk("async_hs3", hs3, 0);
    repeat (2) tick();
    Reset_n = 1'b1;
    En = 1'b1;
    fs_times.delete();
    cyc0 = cyc;
    repeat (6) tick();
    chk("fs_after_reset", fs_times.size() > 0 ? fs_times[0] - cyc0 : -1, 2);
    repeat (60) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
